// File: rtl/demux1to4_buf_pkg.sv
// ----------------------------------------------------------------------------
// demux1to4_buf_pkg
// Shared definitions for the registered 1-to-4 demultiplexer:
//   - default lane data width
//   - lane index type and lane index constants (a, b, c, d)
// ----------------------------------------------------------------------------
package demux1to4_buf_pkg;

  // Default width of the input word and of every output lane.
  localparam int WIDTH_DEF = 2;

  // Number of output lanes.
  localparam int NUM_LANES = 4;

  // Lane index type, wide enough for the four lanes.
  typedef logic [1:0] lane_t;

  // Lane index constants; these match the sel encoding.
  localparam lane_t LANE_A = 2'b00;
  localparam lane_t LANE_B = 2'b01;
  localparam lane_t LANE_C = 2'b10;
  localparam lane_t LANE_D = 2'b11;

  // One-hot load mask for a lane index.
  function automatic logic [3:0] lane_onehot(input lane_t lane);
    logic [3:0] mask;
    case (lane)
      LANE_A:  mask = 4'b0001;
      LANE_B:  mask = 4'b0010;
      LANE_C:  mask = 4'b0100;
      LANE_D:  mask = 4'b1000;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/demux1to4_buf_lane_buf.sv
// ----------------------------------------------------------------------------
// demux1to4_buf_lane_buf
// One-entry valid/ready holding register for a single output lane.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears valid and data)
//   load       load load_data this cycle (the upstream accept is for this lane)
//   load_data  word to store
//   out_ready  lane consumer accepts the buffered word this cycle
//   data       buffered word (registered; holds its value after a drain)
//   valid      buffer full (registered)
// A load has priority over a drain, so a simultaneous drain and load keeps
// valid high and replaces the word, giving one word per cycle per lane.
// ----------------------------------------------------------------------------
module demux1to4_buf_lane_buf
  import demux1to4_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] data_r;
  logic             valid_r;

  // Holding register: load wins over drain; data is never cleared by a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r  <= '0;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= load_data;
      valid_r <= 1'b1;
    end else if (valid_r && out_ready) begin
      data_r  <= data_r;
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end

  assign data  = data_r;
  assign valid = valid_r;

endmodule

// File: rtl/demux1to4_buf.sv
// ----------------------------------------------------------------------------
// demux1to4_buf
// Registered 1-to-4 demultiplexer with a one-entry buffer per lane.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   auto_en    1: internal wrapping pointer picks the lane; 0: sel picks it
//   sel        manual lane select (00=a, 01=b, 10=c, 11=d)
//   in_data    input word
//   in_valid   input word present
//   in_ready   targeted lane can accept this cycle (combinational, 0 in reset)
//   out_a..d   buffered word of lanes 0..3
//   out_valid  per-lane buffer full (bit i = lane i)
//   out_ready  per-lane consumer accepts (bit i = lane i)
//   cur_lane   lane currently targeted (combinational)
// ----------------------------------------------------------------------------
module demux1to4_buf
  import demux1to4_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             auto_en,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       cur_lane
);

  lane_t      ptr_r;
  lane_t      target_s;
  logic       in_ready_s;
  logic       accept_s;
  logic [3:0] load_s;
  logic [3:0] valid_s;

  // Target lane: the pointer in auto mode, the external select otherwise.
  always_comb begin
    target_s = LANE_A;
    if (auto_en) begin
      target_s = ptr_r;
    end else begin
      target_s = sel;
    end
  end

  // Input is accepted when the target buffer is empty or drains this cycle;
  // reset forces the handshake low regardless of buffer state.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = !valid_s[target_s] || out_ready[target_s];
    end
  end

  assign accept_s = in_valid && in_ready_s;

  // Load strobes: at most one lane loads per cycle, the one being targeted.
  always_comb begin
    load_s = 4'b0000;
    if (accept_s) begin
      load_s = lane_onehot(target_s);
    end else begin
      load_s = 4'b0000;
    end
  end

  // Wrapping lane pointer: advances only on an auto-mode accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= LANE_A;
    end else if (accept_s && auto_en) begin
      ptr_r <= ptr_r + 2'b01;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  demux1to4_buf_lane_buf #(.WIDTH(WIDTH)) u_lane_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s[0]),
    .load_data (in_data),
    .out_ready (out_ready[0]),
    .data      (out_a),
    .valid     (valid_s[0])
  );

  demux1to4_buf_lane_buf #(.WIDTH(WIDTH)) u_lane_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s[1]),
    .load_data (in_data),
    .out_ready (out_ready[1]),
    .data      (out_b),
    .valid     (valid_s[1])
  );

  demux1to4_buf_lane_buf #(.WIDTH(WIDTH)) u_lane_c (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s[2]),
    .load_data (in_data),
    .out_ready (out_ready[2]),
    .data      (out_c),
    .valid     (valid_s[2])
  );

  demux1to4_buf_lane_buf #(.WIDTH(WIDTH)) u_lane_d (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s[3]),
    .load_data (in_data),
    .out_ready (out_ready[3]),
    .data      (out_d),
    .valid     (valid_s[3])
  );

  assign out_valid = valid_s;
  assign in_ready  = in_ready_s;
  assign cur_lane  = target_s;

endmodule

// File: tb/tb_demux1to4_buf.sv
// ----------------------------------------------------------------------------
// tb_demux1to4_buf
// Directed, table-driven bench for demux1to4_buf (WIDTH = 2).
// Inputs change on the falling edge; combinational outputs are checked 1 time
// unit later, registered outputs on the following falling edge.
// ----------------------------------------------------------------------------
module tb_demux1to4_buf;

  logic       clk;
  logic       rst;
  logic       auto_en;
  logic [1:0] sel;
  logic [1:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_a;
  logic [1:0] out_b;
  logic [1:0] out_c;
  logic [1:0] out_d;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] cur_lane;

  int checks;
  int errors;

  demux1to4_buf #(.WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .auto_en   (auto_en),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cur_lane  (cur_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       auto_en;
    logic [1:0] sel;
    logic [1:0] din;
    logic       vld;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [1:0] exp_lane;
    logic [3:0] exp_ov;
    logic [1:0] ea;
    logic [1:0] eb;
    logic [1:0] ec;
    logic [1:0] ed;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic au, input logic [1:0] s, input logic [1:0] d,
                              input logic v, input logic [3:0] o, input logic r,
                              input logic [1:0] l, input logic [3:0] ov,
                              input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] c, input logic [1:0] dd);
    vec_t x;
    x.auto_en = au; x.sel = s; x.din = d; x.vld = v; x.ordy = o;
    x.exp_rdy = r; x.exp_lane = l; x.exp_ov = ov;
    x.ea = a; x.eb = b; x.ec = c; x.ed = dd;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector at a falling edge, check combinational outputs, clock it,
  // then check registered outputs at the next falling edge.
  task automatic apply(input string tag, input vec_t v);
    auto_en   = v.auto_en;
    sel       = v.sel;
    in_data   = v.din;
    in_valid  = v.vld;
    out_ready = v.ordy;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
    check({tag, " cur_lane"}, 32'(cur_lane), 32'(v.exp_lane));
    @(negedge clk);
    check({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_ov));
    check({tag, " out_a"}, 32'(out_a), 32'(v.ea));
    check({tag, " out_b"}, 32'(out_b), 32'(v.eb));
    check({tag, " out_c"}, 32'(out_c), 32'(v.ec));
    check({tag, " out_d"}, 32'(out_d), 32'(v.ed));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; auto_en = 1'b0; sel = 2'b00; in_data = 2'b00;
    in_valid = 1'b0; out_ready = 4'b1111;

    //            au   sel    din    vld   ordy     rdy   lane   ov       a      b      c      d
    // 1: manual mode, all consumers ready
    tbl[0]  = mk(1'b0, 2'b00, 2'b10, 1'b1, 4'b1111, 1'b1, 2'd0, 4'b0001, 2'b10, 2'b00, 2'b00, 2'b00);
    tbl[1]  = mk(1'b0, 2'b01, 2'b00, 1'b1, 4'b1111, 1'b1, 2'd1, 4'b0010, 2'b10, 2'b00, 2'b00, 2'b00);
    tbl[2]  = mk(1'b0, 2'b10, 2'b11, 1'b1, 4'b1111, 1'b1, 2'd2, 4'b0100, 2'b10, 2'b00, 2'b11, 2'b00);
    tbl[3]  = mk(1'b0, 2'b11, 2'b01, 1'b1, 4'b1111, 1'b1, 2'd3, 4'b1000, 2'b10, 2'b00, 2'b11, 2'b01);
    tbl[4]  = mk(1'b0, 2'b00, 2'b01, 1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 2'b10, 2'b00, 2'b11, 2'b01);
    // 2: auto mode, pointer still 0 after manual accepts; wraps 3 -> 0
    tbl[5]  = mk(1'b1, 2'b11, 2'b01, 1'b1, 4'b1111, 1'b1, 2'd0, 4'b0001, 2'b01, 2'b00, 2'b11, 2'b01);
    tbl[6]  = mk(1'b1, 2'b11, 2'b10, 1'b1, 4'b1111, 1'b1, 2'd1, 4'b0010, 2'b01, 2'b10, 2'b11, 2'b01);
    tbl[7]  = mk(1'b1, 2'b11, 2'b11, 1'b1, 4'b1111, 1'b1, 2'd2, 4'b0100, 2'b01, 2'b10, 2'b11, 2'b01);
    tbl[8]  = mk(1'b1, 2'b11, 2'b00, 1'b1, 4'b1111, 1'b1, 2'd3, 4'b1000, 2'b01, 2'b10, 2'b11, 2'b00);
    tbl[9]  = mk(1'b1, 2'b11, 2'b01, 1'b1, 4'b1111, 1'b1, 2'd0, 4'b0001, 2'b01, 2'b10, 2'b11, 2'b00);
    // 3: lane c stalled; second word blocked, out_c holds
    tbl[10] = mk(1'b0, 2'b10, 2'b11, 1'b1, 4'b1011, 1'b1, 2'd2, 4'b0100, 2'b01, 2'b10, 2'b11, 2'b00);
    tbl[11] = mk(1'b0, 2'b10, 2'b01, 1'b1, 4'b1011, 1'b0, 2'd2, 4'b0100, 2'b01, 2'b10, 2'b11, 2'b00);
    tbl[12] = mk(1'b0, 2'b10, 2'b01, 1'b1, 4'b1011, 1'b0, 2'd2, 4'b0100, 2'b01, 2'b10, 2'b11, 2'b00);
    // 4: independent lane b accepts while c is stalled
    tbl[13] = mk(1'b0, 2'b01, 2'b10, 1'b1, 4'b1011, 1'b1, 2'd1, 4'b0110, 2'b01, 2'b10, 2'b11, 2'b00);
    // 3 cont.: release c, same edge drains 11 and loads 01
    tbl[14] = mk(1'b0, 2'b10, 2'b01, 1'b1, 4'b1111, 1'b1, 2'd2, 4'b0100, 2'b01, 2'b10, 2'b01, 2'b00);
    // pointer held at 1 through the manual accepts
    tbl[15] = mk(1'b1, 2'b00, 2'b00, 1'b0, 4'b1111, 1'b1, 2'd1, 4'b0000, 2'b01, 2'b10, 2'b01, 2'b00);

    // Reset state
    @(negedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h0);
    check("rst out_data", 32'({out_a, out_b, out_c, out_d}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply($sformatf("v%0d", i), tbl[i]);
    end

    // 5: build out_valid=1011 with ptr=2, then reset between edges.
    // Lane b filled manually, then auto (ptr=1) is blocked: pointer must hold.
    apply("s0", mk(1'b0, 2'b01, 2'b11, 1'b1, 4'b0000, 1'b1, 2'd1, 4'b0010, 2'b01, 2'b11, 2'b01, 2'b00));
    apply("s1", mk(1'b1, 2'b00, 2'b10, 1'b1, 4'b0000, 1'b0, 2'd1, 4'b0010, 2'b01, 2'b11, 2'b01, 2'b00));
    // Drain and reload lane b in auto mode: pointer 1 -> 2
    apply("s2", mk(1'b1, 2'b00, 2'b10, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0010, 2'b01, 2'b10, 2'b01, 2'b00));
    apply("s3", mk(1'b0, 2'b00, 2'b11, 1'b1, 4'b0000, 1'b1, 2'd0, 4'b0011, 2'b11, 2'b10, 2'b01, 2'b00));
    apply("s4", mk(1'b0, 2'b11, 2'b10, 1'b1, 4'b0000, 1'b1, 2'd3, 4'b1011, 2'b11, 2'b10, 2'b01, 2'b10));
    auto_en = 1'b1; in_valid = 1'b0;
    #1;
    check("s5 ptr=2", 32'(cur_lane), 32'd2);
    check("s5 out_valid", 32'(out_valid), 32'hb);
    #1;
    rst = 1'b1;
    #1;
    check("arst out_valid", 32'(out_valid), 32'h0);
    check("arst in_ready", 32'(in_ready), 32'h0);
    check("arst out_data", 32'({out_a, out_b, out_c, out_d}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    apply("r0", mk(1'b1, 2'b11, 2'b11, 1'b1, 4'b1111, 1'b1, 2'd0, 4'b0001, 2'b11, 2'b00, 2'b00, 2'b00));
    apply("r1", mk(1'b1, 2'b11, 2'b01, 1'b1, 4'b1111, 1'b1, 2'd1, 4'b0010, 2'b11, 2'b01, 2'b00, 2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
